// File: rtl/stack_loader_if.sv
// Bus bundle between stack_loader and its neighbours: the Avalon-MM read
// port it masters and register-file write port A.
interface stack_loader_if #(
    parameter int IDX_W  = 5,
    parameter int TTAG_W = 5
);
    // Handshake: mem_read is the request valid and !mem_waitrequest is ready.
    // A read completes in a cycle where both hold; until then the master keeps
    // mem_address and mem_read stable. rf_write_en is a one-cycle write strobe.
    logic [31:0]       mem_address;
    logic              mem_read;
    logic [31:0]       mem_readdata;
    logic              mem_waitrequest;
    logic [IDX_W-1:0]  rf_idx;
    logic [31:0]       rf_writedata;
    logic [TTAG_W-1:0] rf_writetype;
    logic              rf_write_en;

    modport master (
        output mem_address, mem_read,
        input  mem_readdata, mem_waitrequest,
        output rf_idx, rf_writedata, rf_writetype, rf_write_en
    );

    modport slave (
        input  mem_address, mem_read,
        output mem_readdata, mem_waitrequest,
        input  rf_idx, rf_writedata, rf_writetype, rf_write_en
    );
endinterface

// File: rtl/stack_loader.sv
// Bulk loader: reads count TValues (value word, then tag word) starting at
// base and writes them into register-file port A at indices 0..count-1.
module stack_loader #(
    parameter int NREGS   = 32,
    parameter int IDX_W   = 5,
    parameter int TTAG_W  = 5,
    parameter int TV_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [IDX_W:0]   count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state,
    stack_loader_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_VAL = 2'd1,
        RD_TT  = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam logic [IDX_W:0] NREGS_W = (IDX_W+1)'(NREGS);
    localparam logic [IDX_W:0] ONE_W   = (IDX_W+1)'(1);

    state_t         r_state;
    logic [IDX_W:0] r_i;
    logic [IDX_W:0] r_count;
    logic [31:0]    r_base;
    logic [31:0]    r_val;
    logic [31:0]    r_addr;
    logic           r_read;
    logic           r_busy;
    logic           r_done;

    logic [IDX_W:0] w_count_clamped;
    logic [IDX_W:0] w_i_next;
    logic [31:0]    w_next_slot_addr;
    logic           w_we;

    assign w_count_clamped  = (count > NREGS_W) ? NREGS_W : count;
    assign w_i_next         = r_i + ONE_W;
    assign w_next_slot_addr = r_base + 32'(TV_SIZE) * 32'(w_i_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_count <= '0;
            r_base  <= '0;
            r_val   <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= base;
                        r_count <= w_count_clamped;
                        r_i     <= '0;
                        r_busy  <= 1'b1;
                        if (w_count_clamped == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RD_VAL;
                            r_read  <= 1'b1;
                            r_addr  <= base;
                        end
                    end
                end
                RD_VAL: begin
                    // val_q is only loaded here, so a value can never pair with another slot's tag
                    if (!bus.mem_waitrequest) begin
                        r_val   <= bus.mem_readdata;
                        r_addr  <= r_addr + 32'd4;
                        r_state <= RD_TT;
                    end
                end
                RD_TT: begin
                    if (!bus.mem_waitrequest) begin
                        r_i <= w_i_next;
                        if (w_i_next == r_count) begin
                            r_state <= FIN;
                            r_read  <= 1'b0;
                            r_addr  <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RD_VAL;
                            r_addr  <= w_next_slot_addr;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The register write fires in the same cycle the tag word arrives.
    assign w_we             = (r_state == RD_TT) && !bus.mem_waitrequest;
    assign bus.rf_write_en  = w_we;
    assign bus.rf_idx       = w_we ? r_i[IDX_W-1:0] : '0;
    assign bus.rf_writedata = w_we ? r_val : '0;
    assign bus.rf_writetype = w_we ? bus.mem_readdata[TTAG_W-1:0] : '0;

    assign bus.mem_address  = r_addr;
    assign bus.mem_read     = r_read;
    assign busy             = r_busy;
    assign done             = r_done;
    assign o_dbg_state      = r_state;
endmodule
